// File: rtl/serv_arb_pkg.sv
// Shared types and defaults for the SERV memory arbiter.
// The FSM encoding here is the one software-visible debug taps expect.
package serv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/serv_arb_timeout.sv
// Grant watchdog counter for the SERV memory arbiter.
// Only instantiated when SERV_ARB_TIMEOUT_EN is defined.
module serv_arb_timeout
    import serv_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_count) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/serv_mem_arbiter.sv
// Two-master (ibus/dbus) to single Wishbone memory arbiter with alternating tie-break.
// Optional grant watchdog enabled by defining SERV_ARB_TIMEOUT_EN.
module serv_mem_arbiter
    import serv_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_err
);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("serv_mem_arbiter: TIMEOUT out of range 2..65535");
    end

    arb_state_t  state_q, state_d;
    logic        last_d_q, last_d_d;   // 1 = dbus won the previous grant
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        grant;
    logic        busy;
    logic        req_cyc;
    logic        timeout_hit;

    assign busy    = (state_q != IDLE);
    assign req_cyc = (state_q == IGNT) ? i_ibus_cyc : i_dbus_cyc;

`ifdef SERV_ARB_TIMEOUT_EN
    logic expired;

    serv_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (grant),
        .i_count   (busy && !i_wb_ack),
        .o_expired (expired)
    );

    assign timeout_hit = busy && req_cyc && !i_wb_ack && expired;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        grant      = 1'b0;
        o_ibus_ack = 1'b0;
        o_dbus_ack = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie, dbus wins unless it also won last time.
                if (i_dbus_cyc && (!i_ibus_cyc || !last_d_q)) begin
                    state_d  = DGNT;
                    last_d_d = 1'b1;
                    adr_d    = i_dbus_adr;
                    dat_d    = i_dbus_dat;
                    sel_d    = i_dbus_sel;
                    we_d     = i_dbus_we;
                    grant    = 1'b1;
                end else if (i_ibus_cyc) begin
                    state_d  = IGNT;
                    last_d_d = 1'b0;
                    adr_d    = i_ibus_adr;
                    dat_d    = '0;
                    sel_d    = '1;
                    we_d     = 1'b0;
                    grant    = 1'b1;
                end
            end
            IGNT: begin
                if (!i_ibus_cyc) begin
                    state_d = IDLE;
                end else if (i_wb_ack || timeout_hit) begin
                    o_ibus_ack = 1'b1;
                    state_d    = IDLE;
                end
            end
            DGNT: begin
                if (!i_dbus_cyc) begin
                    state_d = IDLE;
                end else if (i_wb_ack || timeout_hit) begin
                    o_dbus_ack = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
        end
    end

    assign o_wb_cyc   = busy;
    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;
    assign o_wb_sel   = sel_q;
    assign o_wb_we    = we_q;
    assign o_ibus_rdt = timeout_hit ? '0 : i_wb_rdt;
    assign o_dbus_rdt = timeout_hit ? '0 : i_wb_rdt;
    assign o_err      = timeout_hit;

endmodule

// File: tb/tb_serv_mem_arbiter.sv
// Scoreboard bench for serv_mem_arbiter; covers the watchdog path when SERV_ARB_TIMEOUT_EN is defined.
module tb_serv_mem_arbiter;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          cyc;
    } grant_t;

    typedef struct {
        logic        is_d;
        logic [31:0] rdt;
        logic        err;
        int          cyc;
    } ack_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ibus_adr = '0;
    logic        ibus_cyc = 1'b0;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic [31:0] dbus_adr = '0;
    logic [31:0] dbus_dat = '0;
    logic [3:0]  dbus_sel = '0;
    logic        dbus_we  = 1'b0;
    logic        dbus_cyc = 1'b0;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic [31:0] wb_rdt = '0;
    logic        wb_ack = 1'b0;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    grant_t grant_q[$];
    ack_t   ack_q[$];

    serv_mem_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ibus_adr (ibus_adr),
        .i_ibus_cyc (ibus_cyc),
        .o_ibus_rdt (ibus_rdt),
        .o_ibus_ack (ibus_ack),
        .i_dbus_adr (dbus_adr),
        .i_dbus_dat (dbus_dat),
        .i_dbus_sel (dbus_sel),
        .i_dbus_we  (dbus_we),
        .i_dbus_cyc (dbus_cyc),
        .o_dbus_rdt (dbus_rdt),
        .o_dbus_ack (dbus_ack),
        .o_wb_adr   (wb_adr),
        .o_wb_dat   (wb_dat),
        .o_wb_sel   (wb_sel),
        .o_wb_we    (wb_we),
        .o_wb_cyc   (wb_cyc),
        .i_wb_rdt   (wb_rdt),
        .i_wb_ack   (wb_ack),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ibus_grant(input logic [31:0] adr);
        grant_q.push_back('{adr: adr, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: cyc_cnt + 1});
    endtask

    task automatic exp_dbus_grant(input logic [31:0] adr, input logic [31:0] dat,
                                  input logic [3:0] sel, input logic we);
        grant_q.push_back('{adr: adr, dat: dat, sel: sel, we: we, cyc: cyc_cnt + 1});
    endtask

    // Raise i_wb_ack for the current cycle and expect the combinational ack now.
    task automatic ack_now(input logic is_d, input logic [31:0] rdt);
        wb_ack = 1'b1;
        wb_rdt = rdt;
        ack_q.push_back('{is_d: is_d, rdt: rdt, err: 1'b0, cyc: cyc_cnt});
    endtask

    // Monitor: pops expectations whenever the DUT starts a grant or acks a requester.
    bit          prev_cyc = 1'b0;
    logic [31:0] hold_adr, hold_dat;
    logic [3:0]  hold_sel;
    logic        hold_we;

    always @(negedge clk) begin
        if (ibus_ack === 1'b1 && dbus_ack === 1'b1) begin
            chk("dual_ack", 2'b11, 2'b00);
        end
        if (wb_cyc === 1'b1 && !prev_cyc) begin
            if (grant_q.size() == 0) begin
                chk("unexpected_grant", {32'h0, wb_adr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                grant_t g;
                g = grant_q.pop_front();
                chk("grant_cycle", 64'(cyc_cnt), 64'(g.cyc));
                chk("grant_adr",   {32'h0, wb_adr}, {32'h0, g.adr});
                chk("grant_dat",   {32'h0, wb_dat}, {32'h0, g.dat});
                chk("grant_sel_we", {59'h0, wb_sel, wb_we}, {59'h0, g.sel, g.we});
            end
            hold_adr = wb_adr;
            hold_dat = wb_dat;
            hold_sel = wb_sel;
            hold_we  = wb_we;
        end else if (wb_cyc === 1'b1) begin
            chk("grant_stable", {wb_adr, wb_dat ^ {27'h0, wb_sel, wb_we}},
                {hold_adr, hold_dat ^ {27'h0, hold_sel, hold_we}});
        end
        if (ibus_ack === 1'b1 || dbus_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", {62'h0, dbus_ack, ibus_ack}, 64'h0);
            end else begin
                ack_t a;
                a = ack_q.pop_front();
                chk("ack_cycle", 64'(cyc_cnt), 64'(a.cyc));
                chk("ack_port",  {62'h0, dbus_ack, ibus_ack}, a.is_d ? 64'd2 : 64'd1);
                chk("ack_rdt",   {32'h0, a.is_d ? dbus_rdt : ibus_rdt}, {32'h0, a.rdt});
                chk("ack_err",   {63'h0, err}, {63'h0, a.err});
            end
        end else if (err === 1'b1) begin
            chk("err_without_ack", 64'd1, 64'd0);
        end
        prev_cyc = (wb_cyc === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_wb_cyc", {63'h0, wb_cyc}, 64'h0);
        chk("rst_wb_adr_dat", {wb_adr, wb_dat}, 64'h0);
        chk("rst_wb_sel_we", {59'h0, wb_sel, wb_we}, 64'h0);
        chk("rst_acks_err", {61'h0, ibus_ack, dbus_ack, err}, 64'h0);

        // ibus read
        ibus_adr = 32'h100;
        ibus_cyc = 1'b1;
        exp_ibus_grant(32'h100);
        tick();
        ack_now(1'b0, 32'h0000_0013);
        tick();
        wb_ack = 1'b0;
        ibus_cyc = 1'b0;
        tick();

        // dbus write, held one extra cycle before ack
        dbus_adr = 32'h2000;
        dbus_dat = 32'hDEAD_BEEF;
        dbus_sel = 4'h3;
        dbus_we  = 1'b1;
        dbus_cyc = 1'b1;
        exp_dbus_grant(32'h2000, 32'hDEAD_BEEF, 4'h3, 1'b1);
        tick();
        tick();
        ack_now(1'b1, 32'h0000_0055);
        tick();
        wb_ack = 1'b0;
        dbus_cyc = 1'b0;
        tick();

        // Tie after reset: dbus, then ibus, then dbus again
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ibus_adr = 32'h300;
        dbus_adr = 32'h400;
        dbus_dat = 32'h11;
        dbus_sel = 4'hC;
        dbus_we  = 1'b0;
        ibus_cyc = 1'b1;
        dbus_cyc = 1'b1;
        exp_dbus_grant(32'h400, 32'h11, 4'hC, 1'b0);
        tick();
        ack_now(1'b1, 32'hA);
        tick();
        wb_ack = 1'b0;
        dbus_cyc = 1'b0;
        chk("tie_idle_gap", {63'h0, wb_cyc}, 64'h0);
        exp_ibus_grant(32'h300);
        tick();
        ack_now(1'b0, 32'hB);
        tick();
        wb_ack = 1'b0;
        dbus_cyc = 1'b1;
        exp_dbus_grant(32'h400, 32'h11, 4'hC, 1'b0);
        tick();
        ack_now(1'b1, 32'hC);
        tick();
        wb_ack = 1'b0;
        ibus_cyc = 1'b0;
        dbus_cyc = 1'b0;
        tick();

        // Reset in grant cycle 3
        ibus_adr = 32'h500;
        ibus_cyc = 1'b1;
        exp_ibus_grant(32'h500);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_wb_cyc", {63'h0, wb_cyc}, 64'h0);
        chk("midrst_acks_err", {61'h0, ibus_ack, dbus_ack, err}, 64'h0);
        ibus_adr = 32'h600;
        exp_ibus_grant(32'h600);
        tick();
        ack_now(1'b0, 32'h1234_5678);
        tick();
        wb_ack = 1'b0;
        ibus_cyc = 1'b0;
        tick();

        // Abort: dbus drops cyc in grant cycle 2, then a late ack in IDLE
        dbus_adr = 32'h700;
        dbus_dat = 32'h77;
        dbus_sel = 4'h1;
        dbus_we  = 1'b1;
        dbus_cyc = 1'b1;
        exp_dbus_grant(32'h700, 32'h77, 4'h1, 1'b1);
        tick();
        tick();
        dbus_cyc = 1'b0;
        tick();
        chk("abort_idle", {63'h0, wb_cyc}, 64'h0);
        wb_ack = 1'b1;
        wb_rdt = 32'h9999;
        #2;
        chk("late_ack_ignored", {62'h0, ibus_ack, dbus_ack}, 64'h0);
        tick();
        wb_ack = 1'b0;
        tick();

`ifdef SERV_ARB_TIMEOUT_EN
        // Watchdog with TIMEOUT=4: forced ack in the 4th grant cycle
        dbus_adr = 32'h800;
        dbus_we  = 1'b0;
        dbus_cyc = 1'b1;
        wb_rdt   = 32'hFFFF_FFFF;
        exp_dbus_grant(32'h800, 32'h77, 4'h1, 1'b0);
        ack_q.push_back('{is_d: 1'b1, rdt: 32'h0, err: 1'b1, cyc: cyc_cnt + 4});
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("timeout_idle", {63'h0, wb_cyc}, 64'h0);
        dbus_cyc = 1'b0;
        tick();
`else
        // Without the watchdog a grant waits indefinitely for i_wb_ack
        dbus_adr = 32'h800;
        dbus_we  = 1'b0;
        dbus_cyc = 1'b1;
        exp_dbus_grant(32'h800, 32'h77, 4'h1, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        chk("no_timeout_cyc_err", {62'h0, wb_cyc, err}, 64'd2);
        ack_now(1'b1, 32'hCAFE);
        tick();
        wb_ack = 1'b0;
        dbus_cyc = 1'b0;
        tick();
`endif

        tick();
        tick();
        chk("grant_queue_empty", 64'(grant_q.size()), 64'd0);
        chk("ack_queue_empty", 64'(ack_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
